tt_um_restador_serial: RTL and testbench

TinyTapeout user block that computes the 4-bit difference A - B bit-serially, one bit per clock, under a start/busy/done handshake. It is the inverse-operation companion to the team's 4-bit adder tile. It uses the same pin map: operand A on ui_in[3:0], operand B on ui_in[7:4]. It latches operands, runs a two's-complement ripple (A + ~B + 1) through a 1-bit datapath, and holds the flagged result on uo_out until the next operation.

---
 rtl/tt_um_restador_serial.sv | 115 +++++++++++
 tb/tb_tt_um_restador_serial.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_restador_serial.sv
// Bit-serial 4-bit subtractor (A - B) for TinyTapeout, with a start/busy/done handshake.
// The ripple A + ~B + 1 runs through a 1-bit datapath, one bit per clock, LSB first.
module tt_um_restador_serial #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_prev_q, start_prev_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         out_q, out_d;

    logic               start_ev;
    logic               sum_bit;
    logic               carry_nxt;
    logic [WIDTH-1:0]   diff_full;
    logic               unused_uio;

    assign start_ev  = uio_in[0] & ~start_prev_q & ena;
    assign sum_bit   = a_q[0] ^ ~b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & ~b_q[0]) | (carry_q & (a_q[0] ^ ~b_q[0]));
    // Result register as it will look once this cycle's bit is shifted in.
    assign diff_full = {sum_bit, res_q[WIDTH-1:1]};
    assign unused_uio = &{1'b0, uio_in[7:1]};

    always_comb begin
        state_d      = state_q;
        start_prev_d = uio_in[0];
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        out_d        = out_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_ev) begin
                    a_d     = ui_in[WIDTH-1:0];
                    b_d     = ui_in[2*WIDTH-1:WIDTH];
                    res_d   = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = diff_full;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Final carry of A + ~B + 1 is the inverted borrow.
                    out_d   = {1'b1, 1'b0, (diff_full == '0), ~carry_nxt, diff_full};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_q        <= out_d;
        end
    end

    assign uo_out  = out_q;
    assign uio_out = {5'b0, done_q, busy_q, 1'b0};
    assign uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_tt_um_restador_serial.sv
// Self-checking bench for tt_um_restador_serial: vector table, hand sequences and random
// stimulus against a transaction-level model (result = A - B, ready 4 cycles after start).
module tb_tt_um_restador_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_restador_serial dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model state
    int       m_left = 0;
    logic     m_prev = 1'b0;
    logic     m_done = 1'b0;
    logic [3:0] m_a = 4'h0, m_b = 4'h0;
    logic [7:0] m_out = 8'h00;

    function automatic logic [7:0] expect_result(input logic [3:0] a, input logic [3:0] b);
        int diff;
        diff = (int'(a) - int'(b) + 16) % 16;
        return {1'b1, 1'b0, (diff == 0), (a < b), 4'(diff)};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic e, input logic r);
        logic ev;
        ui_in = ui; uio_in = uio; ena = e; rst_n = r;
        @(posedge clk);
        if (!r) begin
            m_left = 0; m_prev = 1'b0; m_done = 1'b0; m_out = 8'h00;
        end else begin
            ev = uio[0] && !m_prev && e;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_out  = expect_result(m_a, m_b);
                    m_done = 1'b1;
                end
            end else if (ev) begin
                m_a = ui[3:0]; m_b = ui[7:4]; m_left = 4;
            end
            m_prev = uio[0];
        end
        #1;
        check8("uo_out", uo_out, m_out);
        check8("uio_out", uio_out, {5'b0, m_done, (m_left > 0), 1'b0});
        check8("uio_oe", uio_oe, 8'h06);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];
    int done_cnt;
    int busy_cnt;

    initial begin
        vecs[0] = '{4'd9, 4'd3, 8'h86};
        vecs[1] = '{4'd3, 4'd9, 8'h9A};
        vecs[2] = '{4'd0, 4'd15, 8'h91};
        vecs[3] = '{4'd7, 4'd7, 8'hA0};
        vecs[4] = '{4'd5, 4'd2, 8'h83};
        vecs[5] = '{4'd15, 4'd0, 8'h8F};
        vecs[6] = '{4'd0, 4'd0, 8'hA0};

        // Reset state
        step(8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        check8("reset_uo", uo_out, 8'h00);
        check8("reset_uio", uio_out, 8'h00);

        // Table: one pulse-started operation per vector, busy counted, result vs constant
        foreach (vecs[i]) begin
            busy_cnt = 0;
            done_cnt = 0;
            step({vecs[i].b, vecs[i].a}, 8'h01, 1'b1, 1'b1);
            if (uio_out[1]) busy_cnt++;
            for (int k = 0; k < 5; k++) begin
                step({vecs[i].b, vecs[i].a}, 8'h00, 1'b1, 1'b1);
                if (uio_out[1]) busy_cnt++;
                if (uio_out[2]) done_cnt++;
            end
            check8("table_result", uo_out, vecs[i].exp);
            check8("table_busy_cycles", 8'(busy_cnt), 8'd4);
            check8("table_done_pulses", 8'(done_cnt), 8'd1);
        end

        // Start held high for 20 cycles: exactly one operation
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(8'h25, 8'h01, 1'b1, 1'b1);
            if (uio_out[2]) done_cnt++;
        end
        check8("held_start_done_pulses", 8'(done_cnt), 8'd1);
        check8("held_start_result", uo_out, 8'h83);
        step(8'h25, 8'h00, 1'b1, 1'b1);

        // Operand change during SHIFT, plus a second start request while busy
        step(8'h39, 8'h01, 1'b1, 1'b1);
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        step(8'hFF, 8'h01, 1'b1, 1'b1);
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        check8("ui_change_result", uo_out, 8'h86);
        check8("ui_change_done", uio_out, 8'h04);
        // Start during the done cycle must be accepted: drop start first, then raise it
        step(8'h77, 8'h01, 1'b1, 1'b1);
        check8("start_in_done_busy", uio_out, 8'h02);
        for (int k = 0; k < 4; k++) step(8'h00, 8'h00, 1'b1, 1'b1);
        check8("start_in_done_result", uo_out, 8'hA0);
        step(8'h00, 8'h00, 1'b1, 1'b1);

        // ena low blocks a start
        step(8'h12, 8'h01, 1'b0, 1'b1);
        check8("ena_low_busy", uio_out, 8'h00);
        step(8'h12, 8'h00, 1'b0, 1'b1);
        check8("ena_low_uo", uo_out, 8'hA0);

        // Reset in the middle of SHIFT aborts without a done pulse
        step(8'h39, 8'h01, 1'b1, 1'b1);
        step(8'h39, 8'h00, 1'b1, 1'b1);
        step(8'h39, 8'h00, 1'b1, 1'b0);
        check8("abort_uo", uo_out, 8'h00);
        check8("abort_uio", uio_out, 8'h00);
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(8'h39, 8'h00, 1'b1, 1'b1);
            if (uio_out[2]) done_cnt++;
        end
        check8("abort_no_done", 8'(done_cnt), 8'd0);

        // Full operation after the abort
        step(8'hE4, 8'h01, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(8'h00, 8'h00, 1'b1, 1'b1);
        check8("after_abort_result", uo_out, expect_result(4'h4, 4'hE));

        // Random stimulus against the model
        for (int k = 0; k < 600; k++) begin
            step(8'($urandom), {7'($urandom), 1'($urandom_range(0, 1))},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 50) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
